seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
//   Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
//   Shares one bcd_to_seven_seg decoder across all digits:
//     - drives the current digit's BCD code to the decoder;
//     - gates the returned segments;
//     - walks the anodes one digit at a time.
//   Inserts blanking gaps between digits (anti-ghosting).
//   Applies new digit values only at frame boundaries (tear-free).
// PARAMETERS
//   NUM_DIGITS    4     digits scanned; >=2
//   REFRESH_DIV   1000  clk cycles per digit ON phase; >=1
//   BLANK_CYCLES  2     clk cycles of blanking before each digit; >=1
// PORTS
//   clk        in   1              system clock, all logic on rising edge
//   rst        in   1              synchronous reset, active-high
//   load       in   1              1-cycle strobe: capture digits_in/dp_in as pending frame
//   digits_in  in   4*NUM_DIGITS   BCD digits; [3:0] = digit 0 (least significant)
//   dp_in      in   NUM_DIGITS     decimal point per digit, 1 = lit
//   lz_en      in   1              1 = suppress leading zeros
//   bcd_out    out  4              to shared decoder .bcd
//   seg_in     in   7              from shared decoder .seg_out, active-high segments
//   seg_out    out  7              to display, active-high, 0 = blank
//   dp_out     out  1              to display decimal point, active-high
//   an_out     out  NUM_DIGITS     anode enables, active-low (1 = digit off)
//   frame_done out  1              1-cycle pulse at end of each full scan
// BEHAVIOUR
//   Reset (rst=1 at clock edge):
//     - state=BLANK, idx=0, cnt=0;
//     - an_out=all 1s, seg_out=0, dp_out=0, frame_done=0;
//     - display regs=0, pending regs=0, pend_vld=0.
//     - Reset mid-scan aborts the scan immediately; no partial digit is completed.
//   FSM, two states; one digit slot = BLANK_CYCLES + REFRESH_DIV cycles:
//     - BLANK: an_out all 1s, seg_out=0, dp_out=0.
//       cnt counts 0..BLANK_CYCLES-1, then -> SHOW with cnt=0.
//     - SHOW: an_out[idx]=0, all other bits 1.
//       cnt counts 0..REFRESH_DIV-1, then -> BLANK with cnt=0 and idx advances.
//       idx wraps from NUM_DIGITS-1 to 0.
//   an_out is registered: it reflects the state of the current cycle.
//     No cycle ever has more than one an_out bit low.
//   bcd_out = display[idx], combinational from the registered idx; valid in BLANK and SHOW.
//   seg_out is combinational on seg_in:
//     - seg_out = seg_in in SHOW when the digit is not suppressed;
//     - seg_out = 0 otherwise.
//     - The decoder's combinational path is settled during BLANK.
//   dp_out = display_dp[idx] in SHOW, else 0. A suppressed digit still shows its dp.
//   Invalid BCD (display[idx] > 9): seg_out forced 0 regardless of seg_in.
//   Leading-zero suppression (lz_en=1):
//     - digit k is suppressed when display[k..NUM_DIGITS-1] are all 0 and k != 0;
//     - digit 0 is never suppressed.
//   Frame update:
//     - load=1 captures digits_in/dp_in into the pending regs and sets pend_vld.
//     - Back-to-back loads: the last one wins.
//     - At the wrap transition (SHOW end with idx=NUM_DIGITS-1):
//       if pend_vld, pending -> display and pend_vld is cleared.
//     - frame_done=1 for exactly that cycle.
//     - If load coincides with the wrap, the digits_in of that cycle go directly to display
//       and pend_vld ends 0.
//   lz_en is sampled combinationally (no frame sync).
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, decoder instantiated)
//   1. Reset, then idle -> an_out=1111 for 1 cycle, then 1110 for 4 cycles, then 1111 for 1, then 1101 ...
//      frame_done pulses every 20 cycles; bcd_out=0 throughout.
//   2. load digits_in=16'h4321 mid-frame -> the current frame still shows 0s.
//      The next frame shows 1,2,3,4 on digits 0..3; seg_out matches the decoder codes.
//   3. digits_in=16'h0050, lz_en=1:
//      -> digits 3 and 2 blank (seg_out=0, anode still swept);
//      -> digit 1 shows 5, digit 0 shows 0.
//      With lz_en=0, all four digits are shown.
//   4. digits_in=16'h00A7 -> the digit holding 4'hA has seg_out=0; digit 0 shows 7.
//      dp_in=4'b0100 -> dp_out=1 only while an_out=1011.
//   5. load asserted on the wrap cycle with 16'h9999, plus an earlier load of 16'h1111
//      -> the next frame shows 9999 and pend_vld=0.
//   6. rst asserted mid SHOW of digit 2 -> next cycle an_out=1111, idx=0, display=0.
//      Check every cycle: at most one an_out bit is low.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed scan controller for an N-digit 7-segment display
// Also holds the shared hex glyph decoder; the controller blanks any non-BCD code itself.

module bcd_to_seven_seg (
  input  logic [3:0] bcd,
  output logic [6:0] seg_out
);

  // seg_out = {g,f,e,d,c,b,a}, active-high
  always_comb begin
    seg_out = 7'h00;
    case (bcd)
      4'h0: seg_out = 7'h3F;
      4'h1: seg_out = 7'h06;
      4'h2: seg_out = 7'h5B;
      4'h3: seg_out = 7'h4F;
      4'h4: seg_out = 7'h66;
      4'h5: seg_out = 7'h6D;
      4'h6: seg_out = 7'h7D;
      4'h7: seg_out = 7'h07;
      4'h8: seg_out = 7'h7F;
      4'h9: seg_out = 7'h6F;
      4'hA: seg_out = 7'h77;
      4'hB: seg_out = 7'h7C;
      4'hC: seg_out = 7'h39;
      4'hD: seg_out = 7'h5E;
      4'hE: seg_out = 7'h79;
      4'hF: seg_out = 7'h71;
      default: seg_out = 7'h00;
    endcase
  end

endmodule

module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic [3:0]              bcd_out,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_vld_q, pend_vld_d;
  logic                    wrap;

  logic [3:0]              cur_bcd;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    suppressed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      idx_q      <= '0;
      an_q       <= '1;
      disp_q     <= '0;
      pend_q     <= '0;
      disp_dp_q  <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      disp_dp_q  <= disp_dp_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    wrap    = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_BLANK;
    endcase

    // Anodes are registered from the next state so they line up with state_q.
    an_d = '1;
    if (state_d == ST_SHOW) an_d[idx_d] = 1'b0;
  end

  always_comb begin
    disp_d     = disp_q;
    disp_dp_d  = disp_dp_q;
    pend_d     = pend_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    if (load) begin
      pend_d     = digits_in;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end
    // A load landing on the wrap bypasses the pending copy entirely.
    if (wrap) begin
      if (load) begin
        disp_d     = digits_in;
        disp_dp_d  = dp_in;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        disp_d     = pend_q;
        disp_dp_d  = pend_dp_q;
        pend_vld_d = 1'b0;
      end
    end
  end

  always_comb begin
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run          = run && (disp_q[4*k +: 4] == 4'd0);
      lead_zero[k] = run;
    end
  end

  always_comb begin
    cur_bcd    = disp_q[4*idx_q +: 4];
    suppressed = lz_en && (idx_q != '0) && lead_zero[idx_q];
    bcd_out    = cur_bcd;
    an_out     = an_q;
    frame_done = wrap;
    seg_out    = 7'h00;
    dp_out     = 1'b0;
    if (state_q == ST_SHOW) begin
      dp_out = disp_dp_q[idx_q];
      if (!suppressed && (cur_bcd <= 4'd9)) seg_out = seg_in;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - directed bench for seven_seg_scan_ctrl with the shared decoder
// Frame layout at 4 digits, 4 show / 1 blank: cycle c, digit c/5, blank when c%5==0.

module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [3:0]  bcd_out;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  logic [3:0] an_log  [20];
  logic [6:0] seg_log [20];
  logic       dp_log  [20];
  logic [3:0] bcd_log [20];
  logic       fd_log  [20];
  logic [6:0] seg_code[16];

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .lz_en     (lz_en),
    .bcd_out   (bcd_out),
    .seg_in    (seg_in),
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .an_out    (an_out),
    .frame_done(frame_done)
  );

  bcd_to_seven_seg u_dec (
    .bcd    (bcd_out),
    .seg_out(seg_in)
  );

  initial begin
    #100000;
    $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  task automatic capture_frame();
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      an_log[c]  = an_out;
      seg_log[c] = seg_out;
      dp_log[c]  = dp_out;
      bcd_log[c] = bcd_out;
      fd_log[c]  = frame_done;
    end
  endtask

  task automatic wait_frame_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL wait_frame_done: frame_done=%b after %0d cycles, required 1", frame_done, n);
    end
  endtask

  task automatic goto_frame_start();
    wait_frame_done();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (an_out !== 4'hF) begin errors++; $display("FAIL reset_an: got %b required 1111", an_out); end
    checks++; if (seg_out !== 7'h00) begin errors++; $display("FAIL reset_seg: got %h required 00", seg_out); end
    checks++; if (dp_out !== 1'b0) begin errors++; $display("FAIL reset_dp: got %b required 0", dp_out); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b required 0", frame_done); end
    checks++; if (bcd_out !== 4'h0) begin errors++; $display("FAIL reset_bcd: got %h required 0", bcd_out); end
    checks++; if (dut.pend_vld_q !== 1'b0) begin errors++; $display("FAIL reset_pend_vld: got %b required 0", dut.pend_vld_q); end
    rst = 1'b0;
    capture_frame();
    for (int c = 0; c < 20; c++) begin
      exp_an  = (c % 5 == 0) ? 4'hF : ~(4'(1) << (c / 5));
      exp_seg = (c % 5 == 0) ? 7'h00 : seg_code[0];
      checks++; if (an_log[c] !== exp_an) begin errors++; $display("FAIL idle_an c=%0d: got %b required %b", c, an_log[c], exp_an); end
      checks++; if (bcd_log[c] !== 4'h0) begin errors++; $display("FAIL idle_bcd c=%0d: got %h required 0", c, bcd_log[c]); end
      checks++; if (seg_log[c] !== exp_seg) begin errors++; $display("FAIL idle_seg c=%0d: got %h required %h", c, seg_log[c], exp_seg); end
      checks++; if (fd_log[c] !== (c == 19)) begin errors++; $display("FAIL idle_fd c=%0d: got %b required %b", c, fd_log[c], c == 19); end
    end
  endtask

  task automatic test_load_mid_frame();
    logic [3:0] ed;
    goto_frame_start();
    repeat (7) @(negedge clk);
    checks++; if (an_out !== 4'b1101) begin errors++; $display("FAIL mid_pos_an: got %b required 1101", an_out); end
    digits_in = 16'h4321;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++; if (dut.pend_vld_q !== 1'b1) begin errors++; $display("FAIL mid_pend_vld: got %b required 1", dut.pend_vld_q); end
    for (int c = 8; c < 20; c++) begin
      checks++; if (bcd_out !== 4'h0) begin errors++; $display("FAIL mid_old_frame c=%0d: bcd %h required 0", c, bcd_out); end
      if (c == 19) begin
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL mid_wrap_fd: got %b required 1", frame_done); end
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      ed = 4'(d + 1);
      checks++; if (bcd_log[d*5] !== ed) begin errors++; $display("FAIL new_bcd_blank d=%0d: got %h required %h", d, bcd_log[d*5], ed); end
      checks++; if (seg_log[d*5] !== 7'h00) begin errors++; $display("FAIL new_seg_blank d=%0d: got %h required 00", d, seg_log[d*5]); end
      checks++; if (bcd_log[d*5+2] !== ed) begin errors++; $display("FAIL new_bcd d=%0d: got %h required %h", d, bcd_log[d*5+2], ed); end
      checks++; if (seg_log[d*5+2] !== seg_code[ed]) begin errors++; $display("FAIL new_seg d=%0d: got %h required %h", d, seg_log[d*5+2], seg_code[ed]); end
    end
    checks++; if (dut.pend_vld_q !== 1'b0) begin errors++; $display("FAIL new_pend_clr: got %b required 0", dut.pend_vld_q); end
  endtask

  task automatic test_lz_back_to_back();
    logic [3:0] exp_an;
    @(negedge clk);
    digits_in = 16'h1234;
    load = 1'b1;
    @(negedge clk);
    digits_in = 16'h0050;
    @(negedge clk);
    load = 1'b0;
    lz_en = 1'b1;
    goto_frame_start();
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      exp_an = ~(4'(1) << d);
      checks++; if (an_log[d*5+2] !== exp_an) begin errors++; $display("FAIL lz_an d=%0d: got %b required %b", d, an_log[d*5+2], exp_an); end
    end
    checks++; if (seg_log[2] !== 7'h3F) begin errors++; $display("FAIL lz_d0: got %h required 3f", seg_log[2]); end
    checks++; if (seg_log[7] !== 7'h6D) begin errors++; $display("FAIL lz_d1: got %h required 6d", seg_log[7]); end
    checks++; if (bcd_log[7] !== 4'h5) begin errors++; $display("FAIL lz_d1_bcd: got %h required 5", bcd_log[7]); end
    checks++; if (seg_log[12] !== 7'h00) begin errors++; $display("FAIL lz_d2: got %h required 00", seg_log[12]); end
    checks++; if (seg_log[17] !== 7'h00) begin errors++; $display("FAIL lz_d3: got %h required 00", seg_log[17]); end
    lz_en = 1'b0;
    @(negedge clk);
    capture_frame();
    checks++; if (seg_log[12] !== 7'h3F) begin errors++; $display("FAIL nolz_d2: got %h required 3f", seg_log[12]); end
    checks++; if (seg_log[17] !== 7'h3F) begin errors++; $display("FAIL nolz_d3: got %h required 3f", seg_log[17]); end
    checks++; if (seg_log[7] !== 7'h6D) begin errors++; $display("FAIL nolz_d1: got %h required 6d", seg_log[7]); end
  endtask

  task automatic test_invalid_dp();
    logic exp_dp;
    @(negedge clk);
    digits_in = 16'h00A7;
    dp_in = 4'b0100;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    dp_in = 4'b0000;
    goto_frame_start();
    capture_frame();
    checks++; if (seg_log[2] !== 7'h07) begin errors++; $display("FAIL inv_d0: got %h required 07", seg_log[2]); end
    checks++; if (bcd_log[7] !== 4'hA) begin errors++; $display("FAIL inv_d1_bcd: got %h required a", bcd_log[7]); end
    checks++; if (seg_log[7] !== 7'h00) begin errors++; $display("FAIL inv_d1_seg: got %h required 00", seg_log[7]); end
    checks++; if (seg_log[12] !== 7'h3F) begin errors++; $display("FAIL inv_d2: got %h required 3f", seg_log[12]); end
    for (int c = 0; c < 20; c++) begin
      exp_dp = (c >= 11 && c <= 14);
      checks++; if (dp_log[c] !== exp_dp) begin errors++; $display("FAIL dp c=%0d: got %b required %b (an %b)", c, dp_log[c], exp_dp, an_log[c]); end
    end
  endtask

  task automatic test_load_on_wrap();
    @(negedge clk);
    digits_in = 16'h1111;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_frame_done();
    checks++; if (dut.pend_vld_q !== 1'b1) begin errors++; $display("FAIL wrap_pend_before: got %b required 1", dut.pend_vld_q); end
    digits_in = 16'h9999;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++; if (dut.pend_vld_q !== 1'b0) begin errors++; $display("FAIL wrap_pend_after: got %b required 0", dut.pend_vld_q); end
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      checks++; if (bcd_log[d*5+2] !== 4'h9) begin errors++; $display("FAIL wrap_bcd d=%0d: got %h required 9", d, bcd_log[d*5+2]); end
      checks++; if (seg_log[d*5+2] !== 7'h6F) begin errors++; $display("FAIL wrap_seg d=%0d: got %h required 6f", d, seg_log[d*5+2]); end
    end
  endtask

  task automatic test_reset_mid_show();
    logic [3:0] exp_an;
    @(negedge clk);
    repeat (12) @(negedge clk);
    checks++; if (an_out !== 4'b1011) begin errors++; $display("FAIL rst_pos_an: got %b required 1011", an_out); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (an_out !== 4'hF) begin errors++; $display("FAIL rst_mid_an: got %b required 1111", an_out); end
    checks++; if (seg_out !== 7'h00) begin errors++; $display("FAIL rst_mid_seg: got %h required 00", seg_out); end
    checks++; if (bcd_out !== 4'h0) begin errors++; $display("FAIL rst_mid_bcd: got %h required 0", bcd_out); end
    checks++; if (dut.idx_q !== 2'd0) begin errors++; $display("FAIL rst_mid_idx: got %0d required 0", dut.idx_q); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_mid_fd: got %b required 0", frame_done); end
    rst = 1'b0;
    capture_frame();
    for (int c = 0; c < 20; c++) begin
      exp_an = (c % 5 == 0) ? 4'hF : ~(4'(1) << (c / 5));
      checks++; if ($countones(~an_log[c]) > 1) begin errors++; $display("FAIL an_onehot c=%0d: got %b required at most one low", c, an_log[c]); end
      checks++; if (an_log[c] !== exp_an) begin errors++; $display("FAIL rst_an c=%0d: got %b required %b", c, an_log[c], exp_an); end
      checks++; if (bcd_log[c] !== 4'h0) begin errors++; $display("FAIL rst_bcd c=%0d: got %h required 0", c, bcd_log[c]); end
    end
  endtask

  initial begin
    seg_code[0]  = 7'h3F; seg_code[1]  = 7'h06; seg_code[2]  = 7'h5B; seg_code[3]  = 7'h4F;
    seg_code[4]  = 7'h66; seg_code[5]  = 7'h6D; seg_code[6]  = 7'h7D; seg_code[7]  = 7'h07;
    seg_code[8]  = 7'h7F; seg_code[9]  = 7'h6F; seg_code[10] = 7'h00; seg_code[11] = 7'h00;
    seg_code[12] = 7'h00; seg_code[13] = 7'h00; seg_code[14] = 7'h00; seg_code[15] = 7'h00;
    rst       = 1'b1;
    load      = 1'b0;
    digits_in = 16'h0000;
    dp_in     = 4'b0000;
    lz_en     = 1'b0;

    test_reset();
    test_load_mid_frame();
    test_lz_back_to_back();
    test_invalid_dp();
    test_load_on_wrap();
    test_reset_mid_show();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
